serial_adder_n: RTL and testbench

- Bit-serial, parametrised N-bit adder built around a single full-adder cell and a registered carry.
- Processes operands LSB-first, one bit per clock, trading latency for area.
- Used wherever a wide add is needed but only one full-adder slice can be afforded (low-area datapaths, serial arithmetic units).
- Operands are accepted on a valid/ready handshake; a one-cycle done pulse accompanies each result.

---
 rtl/serial_adder_n_if.sv | 30 +++
 rtl/serial_adder_n.sv | 145 ++++++++++++++
 tb/tb_serial_adder_n.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/serial_adder_n_if.sv
// Handshake and result bundle for serial_adder_n.
// The sub port exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_n_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             done;
  logic             busy;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start_valid, a, b, cin, sub,
                  input  start_ready, sum, cout, done, busy);
  modport slave  (input  start_valid, a, b, cin, sub,
                  output start_ready, sum, cout, done, busy);
`else
  modport master (output start_valid, a, b, cin,
                  input  start_ready, sum, cout, done, busy);
  modport slave  (input  start_valid, a, b, cin,
                  output start_ready, sum, cout, done, busy);
`endif
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, LSB first, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add a subtract mode (a - b) selected by bus.sub.
module serial_adder_n #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_adder_n_if.slave   bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-2:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic [WIDTH-1:0] b_in_s;
  logic             cin_in_s;
  logic             bit_s;
  logic             maj_s;
  logic [WIDTH-1:0] acc_shift_s;

  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  // Operand conditioning at the accept edge (two's-complement subtract when enabled)
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    if (bus.sub) begin
      b_in_s   = ~bus.b;
      cin_in_s = 1'b1;
    end else begin
      b_in_s   = bus.b;
      cin_in_s = bus.cin;
    end
`else
    b_in_s   = bus.b;
    cin_in_s = bus.cin;
`endif
  end

  // Full-adder slice and next-state logic
  always_comb begin
    bit_s       = fa_sum(opa_q[0], opb_q[0], carry_q);
    maj_s       = fa_carry(opa_q[0], opb_q[0], carry_q);
    acc_shift_s = {bit_s, acc_q};
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_valid) begin
          opa_d   = bus.a;
          opb_d   = b_in_s;
          carry_d = cin_in_s;
          cnt_d   = {CW{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = acc_shift_s[WIDTH-1:1];
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        carry_d = maj_s;
        cnt_d   = cnt_q + CW'(1);
        // The final bit lands directly in sum alongside the bits already shifted in
        if (cnt_q == LAST_BIT) begin
          sum_d   = acc_shift_s;
          cout_d  = maj_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      opa_q   <= {WIDTH{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      acc_q   <= {(WIDTH-1){1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bus.sum         = sum_q;
  assign bus.cout        = cout_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;
  assign bus.start_ready = ready_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n (WIDTH=8): directed table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_serial_adder_n;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_adder_n_if #(.WIDTH(W)) bus ();
  serial_adder_n #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    int unsigned r;
    if (sub) r = int'(a) + ((1 << W) - 1 - int'(b)) + 1;
    else     r = int'(a) + int'(b) + int'(cin);
    return (W+1)'(r);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sum"},   32'(bus.sum), 32'h0);
    chk({tag, "_cout"},  32'(bus.cout), 32'h0);
    chk({tag, "_done"},  32'(bus.done), 32'h0);
    chk({tag, "_busy"},  32'(bus.busy), 32'h0);
    chk({tag, "_ready"}, 32'(bus.start_ready), 32'h1);
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input bit hold, input logic [W-1:0] exp_sum,
                        input logic exp_cout, input string tag);
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    prev_sum  = bus.sum;
    prev_cout = bus.cout;
    chk({tag, "_ready_idle"}, 32'(bus.start_ready), 32'h1);
    bus.start_valid = 1'b1;
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = sub;
`endif
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      if (hold) begin
        bus.a   = 8'h01;
        bus.b   = 8'h01;
        bus.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
      end else begin
        bus.start_valid = 1'b0;
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.cin = 1'($urandom);
      end
      chk($sformatf("%s_done_e%0d", tag, k),  32'(bus.done), 32'(k == W));
      chk($sformatf("%s_busy_e%0d", tag, k),  32'(bus.busy), 32'(k <= W));
      chk($sformatf("%s_ready_e%0d", tag, k), 32'(bus.start_ready), 32'(k > W));
      if (k < W) begin
        chk($sformatf("%s_sum_hold_e%0d", tag, k),  32'(bus.sum), 32'(prev_sum));
        chk($sformatf("%s_cout_hold_e%0d", tag, k), 32'(bus.cout), 32'(prev_cout));
      end else begin
        chk($sformatf("%s_sum_e%0d", tag, k),  32'(bus.sum), 32'(exp_sum));
        chk($sformatf("%s_cout_e%0d", tag, k), 32'(bus.cout), 32'(exp_cout));
      end
    end
  endtask

  initial begin
    vec_t         vecs[$];
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    logic [W:0]   r;

    vecs.push_back('{a: 8'h35, b: 8'h1A, cin: 1'b0, sub: 1'b0, exp_sum: 8'h4F, exp_cout: 1'b0});
    vecs.push_back('{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1});
    vecs.push_back('{a: 8'hFF, b: 8'hFF, cin: 1'b1, sub: 1'b0, exp_sum: 8'hFF, exp_cout: 1'b1});
    vecs.push_back('{a: 8'h00, b: 8'h00, cin: 1'b1, sub: 1'b0, exp_sum: 8'h01, exp_cout: 1'b0});
    vecs.push_back('{a: 8'hAA, b: 8'h55, cin: 1'b1, sub: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1});
`ifdef SERIAL_ADDER_SUB_EN
    vecs.push_back('{a: 8'h10, b: 8'h01, cin: 1'b0, sub: 1'b1, exp_sum: 8'h0F, exp_cout: 1'b1});
    vecs.push_back('{a: 8'h01, b: 8'h02, cin: 1'b0, sub: 1'b1, exp_sum: 8'hFF, exp_cout: 1'b0});
    vecs.push_back('{a: 8'h42, b: 8'h42, cin: 1'b0, sub: 1'b1, exp_sum: 8'h00, exp_cout: 1'b1});
`endif

    rst = 1'b1;
    bus.start_valid = 1'b0;
    bus.a   = '0;
    bus.b   = '0;
    bus.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
    #3;
    chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0,
             vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));

    // start_valid held with new operands during RUN/DONE must be ignored
    run_op(8'h12, 8'h34, 1'b1, 1'b0, 1'b1, 8'h47, 1'b0, "hold_first");
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, "hold_second");

    // Abort with an asynchronous reset after the 4th RUN edge
    bus.start_valid = 1'b1;
    bus.a   = 8'h77;
    bus.b   = 8'h66;
    bus.cin = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      bus.start_valid = 1'b0;
    end
    chk("abort_busy_before", 32'(bus.busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_vals("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      chk($sformatf("abort_no_done_%0d", k), 32'(bus.done), 32'h0);
      chk($sformatf("abort_idle_%0d", k),    32'(bus.busy), 32'h0);
    end
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "after_abort");

    for (int n = 0; n < 25; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rs = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      rs = 1'($urandom_range(0, 1));
`endif
      r = ref_add(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, 1'b0, r[W-1:0], r[W], $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
